// File: rtl/nivel2_controle.sv
// Level-2 microwave control: turns panel buttons, door switch and cook timer
// into the registered magnetron enable Q2 through a four-state controller.
module nivel2_controle #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic startn,
  input  logic stopn,
  input  logic clearn,
  input  logic door_closed,
  input  logic timer_done,
  output logic Q2
);

  localparam int NIN = 5;
  // Bit order {timer_done, door_closed, clearn, stopn, startn}; idle = released, door open, timer off
  localparam logic [NIN-1:0] IN_IDLE = 5'b00111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q, sync_d;
  logic [NIN-1:0] in_raw;
  logic [NIN-1:0] in_s;

  logic   start_prev_q, start_prev_d;
  logic   start_evt;
  logic   stop_s, clear_s, door_s, timer_s;
  state_t state_q, state_d;
  logic   q2_q, q2_d;

  assign in_raw = {timer_done, door_closed, clearn, stopn, startn};
  assign in_s   = sync_q[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = in_raw;
      end else begin : g_next
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  assign stop_s  = ~in_s[1];
  assign clear_s = ~in_s[2];
  assign door_s  = in_s[3];
  assign timer_s = in_s[4];

  always_comb begin
    start_prev_d = in_s[0];
    // Edge detect on the synchronised button so a held START fires only once
    start_evt    = start_prev_q & ~in_s[0];
    state_d      = state_q;
    case (state_q)
      IDLE: begin
        if (start_evt && door_s && !timer_s && !stop_s && !clear_s)
          state_d = COOK;
      end
      COOK: begin
        if (clear_s)                 state_d = IDLE;
        else if (stop_s || !door_s)  state_d = PAUSE;
        else if (timer_s)            state_d = DONE;
      end
      PAUSE: begin
        if (clear_s)                                  state_d = IDLE;
        else if (timer_s)                             state_d = DONE;
        else if (start_evt && door_s && !stop_s)      state_d = COOK;
      end
      DONE: begin
        if (clear_s || !door_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    q2_d = (state_d == COOK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= {SYNC_STAGES{IN_IDLE}};
      start_prev_q <= 1'b1;
      state_q      <= IDLE;
      q2_q         <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      start_prev_q <= start_prev_d;
      state_q      <= state_d;
      q2_q         <= q2_d;
    end
  end

  assign Q2 = q2_q;

endmodule

// File: tb/tb_nivel2_controle.sv
// Scenario bench for nivel2_controle: expected Q2 values are queued as each
// stimulus is applied and retired once the input-to-output latency has elapsed.
module tb_nivel2_controle;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic clk = 1'b0;
  logic rst_n, startn, stopn, clearn, door_closed, timer_done;
  logic Q2;

  typedef struct {
    string name;
    logic  exp;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  checks = 0;
  int  errors = 0;

  nivel2_controle #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .timer_done (timer_done),
    .Q2         (Q2)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic cl,
                       input logic dr, input logic tm);
    startn      = st;
    stopn       = sp;
    clearn      = cl;
    door_closed = dr;
    timer_done  = tm;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(i[0], i[1], ~i[0], ~i[1], i[2]);
      sb.push_back('{$sformatf("reset_hold_%0d", i), 1'b0});
      cyc(1);
      e = sb.pop_front();
      checks++;
      if (Q2 !== e.exp) begin
        errors++;
        $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
      end else $display("ok %s Q2=%b", e.name, Q2);
    end
    drive(1, 1, 1, 1, 0);
    rst_n = 1'b1;
    sb.push_back('{"reset_release_idle", 1'b0});
    cyc(LAT + 3);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
  endtask

  task automatic test_start;
    drive(0, 1, 1, 1, 0);
    sb.push_back('{"start_not_early", 1'b0});
    sb.push_back('{"start_latency", 1'b1});
    cyc(LAT - 1);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    cyc(1);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 1, 1, 0);
    sb.push_back('{"start_release_keeps_cook", 1'b1});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
  endtask

  task automatic test_door;
    drive(1, 1, 1, 0, 0);
    sb.push_back('{"door_open_not_early", 1'b1});
    sb.push_back('{"door_open_pause", 1'b0});
    cyc(LAT - 1);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    cyc(1);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 1, 1, 0);
    sb.push_back('{"door_closed_stays_paused", 1'b0});
    cyc(LAT + 2);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(0, 1, 1, 1, 0);
    sb.push_back('{"resume_after_door", 1'b1});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 1, 1, 0);
    cyc(LAT);
  endtask

  task automatic test_timer;
    drive(1, 1, 1, 1, 1);
    sb.push_back('{"timer_done_stops", 1'b0});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(0, 1, 1, 1, 1);
    sb.push_back('{"start_ignored_in_done", 1'b0});
    cyc(LAT + 1);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 1, 1, 0);
    cyc(LAT);
    drive(0, 1, 1, 1, 0);
    sb.push_back('{"done_holds_without_clear", 1'b0});
    cyc(LAT + 1);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 0, 0, 1, 0);
    cyc(LAT);
    drive(1, 1, 1, 1, 0);
    cyc(LAT);
    drive(0, 1, 1, 1, 0);
    sb.push_back('{"clear_returns_idle", 1'b1});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 0, 1, 0);
    sb.push_back('{"clear_stops_cook", 1'b0});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 1, 1, 0);
    cyc(LAT);
  endtask

  task automatic test_priority;
    logic [3:0] blk [4];
    string      nm  [4];
    // {stopn, clearn, door_closed, timer_done} applied together with a START press
    blk[0] = 4'b0110; nm[0] = "prio_stop_over_start";
    blk[1] = 4'b1010; nm[1] = "prio_clear_over_start";
    blk[2] = 4'b1100; nm[2] = "prio_door_over_start";
    blk[3] = 4'b1111; nm[3] = "prio_timer_over_start";
    for (int i = 0; i < 4; i++) begin
      drive(0, blk[i][3], blk[i][2], blk[i][1], blk[i][0]);
      sb.push_back('{nm[i], 1'b0});
      cyc(LAT + 1);
      e = sb.pop_front();
      checks++;
      if (Q2 !== e.exp) begin
        errors++;
        $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
      end else $display("ok %s Q2=%b", e.name, Q2);
      drive(1, 1, 1, 1, 0);
      cyc(LAT);
    end
    drive(0, 1, 1, 1, 0);
    sb.push_back('{"prio_idle_still_starts", 1'b1});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 1, 1, 0);
    cyc(LAT);
  endtask

  task automatic test_held_start;
    drive(0, 0, 1, 1, 0);
    sb.push_back('{"held_stop_pauses", 1'b0});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(0, 1, 1, 1, 0);
    sb.push_back('{"held_start_no_retrigger", 1'b0});
    cyc(LAT + 3);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 1, 1, 0);
    sb.push_back('{"held_release_no_start", 1'b0});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(0, 1, 1, 1, 0);
    sb.push_back('{"held_new_press_resumes", 1'b1});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 1, 1, 0);
    cyc(LAT);
  endtask

  task automatic test_reset_midcook;
    #3;
    rst_n = 1'b0;
    sb.push_back('{"reset_async_drop", 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    cyc(2);
    rst_n = 1'b1;
    sb.push_back('{"reset_no_auto_resume", 1'b0});
    cyc(LAT + 3);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(0, 1, 1, 1, 0);
    sb.push_back('{"reset_new_press_cooks", 1'b1});
    cyc(LAT);
    e = sb.pop_front();
    checks++;
    if (Q2 !== e.exp) begin
      errors++;
      $display("FAIL %s: Q2=%b expected %b", e.name, Q2, e.exp);
    end else $display("ok %s Q2=%b", e.name, Q2);
    drive(1, 1, 1, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1, 1, 1, 0, 0);
    cyc(1);
    test_reset();
    test_start();
    test_door();
    test_timer();
    test_priority();
    drive(0, 1, 1, 1, 0);
    cyc(LAT);
    test_held_start();
    test_reset_midcook();
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
